ascon_round_scheduler: RTL and testbench

- Sequences the Ascon permutation datapath for one p^a or p^b invocation.
- Accepts a start request with a round-count select and loads an internal round down-counter.
- Drives the permutation enable and per-lane round constants each cycle, then reports completion over a valid/ready handshake.
- Sits between the AEAD top-level FSM and the permutation round logic.

---
 rtl/ascon_round_scheduler.sv | 112 +++++++++++
 tb/tb_ascon_round_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ascon_round_scheduler.sv
// Ascon permutation round scheduler: sequences p^a / p^b rounds and round constants.
// Optional abort input enabled by defining ASCON_SCHED_ABORT_EN.
module ascon_round_scheduler #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 8,
    parameter int UNROLL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid_i,
    output logic                  start_ready_o,
    input  logic                  rounds_sel_i,
    input  logic                  stall_i,
    output logic                  perm_en_o,
    output logic [8*UNROLL-1:0]   rc_o,
    output logic                  first_round_o,
    output logic                  last_round_o,
    output logic                  done_valid_o,
    input  logic                  done_ready_i,
    output logic                  busy_o
`ifdef ASCON_SCHED_ABORT_EN
    ,
    input  logic                  abort_i
`endif
);

    localparam int NA   = ROUNDS_A / UNROLL;
    localparam int NB   = ROUNDS_B / UNROLL;
    localparam int NMAX = (NA > NB) ? NA : NB;
    localparam int CW   = $clog2(NMAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4) ||
        (ROUNDS_A % UNROLL) != 0 || (ROUNDS_B % UNROLL) != 0) begin : g_bad_unroll
        $error("ascon_round_scheduler: illegal UNROLL for the round counts");
    end

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    rc_idx;
    logic          sel_q;
    logic          abort;
    logic [CW-1:0] n_cur;

`ifdef ASCON_SCHED_ABORT_EN
    assign abort = abort_i && (state != S_IDLE);
`else
    assign abort = 1'b0;
`endif

    assign n_cur         = sel_q ? CW'(NB) : CW'(NA);
    assign start_ready_o = (state == S_IDLE) && !rst;
    assign busy_o        = (state != S_IDLE);
    assign perm_en_o     = (state == S_RUN) && !stall_i && !abort;
    assign done_valid_o  = (state == S_DONE) && !abort;
    assign first_round_o = perm_en_o && (cnt == n_cur);
    assign last_round_o  = perm_en_o && (cnt == CW'(1));

    // Lane j constant is {~k, k} over nibbles, with k = rc_idx + j.
    always_comb begin
        logic [3:0] k;
        rc_o = '0;
        for (int j = 0; j < UNROLL; j++) begin
            k = rc_idx + 4'(j);
            rc_o[8*j +: 8] = perm_en_o ? {4'hF - k, k} : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rc_idx <= '0;
            sel_q  <= 1'b0;
        end else if (abort) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rc_idx <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_valid_i) begin
                        sel_q  <= rounds_sel_i;
                        cnt    <= rounds_sel_i ? CW'(NB) : CW'(NA);
                        rc_idx <= rounds_sel_i ? 4'(12 - ROUNDS_B)
                                               : 4'(12 - ROUNDS_A);
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall_i) begin
                        cnt    <= cnt - CW'(1);
                        rc_idx <= rc_idx + 4'(UNROLL);
                        if (cnt == CW'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (done_ready_i) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_round_scheduler.sv
// Testbench for ascon_round_scheduler: UNROLL=1 and UNROLL=4 instances,
// scoreboard of expected round constants checked on each enabled cycle.
module tb_ascon_round_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sv1, sv4, sel, stall, dready;

    logic        sr1, pe1, f1, l1, dv1, b1;
    logic [7:0]  rc1;
    logic        sr4, pe4, f4, l4, dv4, b4;
    logic [31:0] rc4;

    ascon_round_scheduler #(.ROUNDS_A(12), .ROUNDS_B(8), .UNROLL(1)) dut1 (
        .clk(clk), .rst(rst), .start_valid_i(sv1), .start_ready_o(sr1),
        .rounds_sel_i(sel), .stall_i(stall), .perm_en_o(pe1), .rc_o(rc1),
        .first_round_o(f1), .last_round_o(l1), .done_valid_o(dv1),
        .done_ready_i(dready), .busy_o(b1)
    );

    ascon_round_scheduler #(.ROUNDS_A(12), .ROUNDS_B(8), .UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .start_valid_i(sv4), .start_ready_o(sr4),
        .rounds_sel_i(sel), .stall_i(stall), .perm_en_o(pe4), .rc_o(rc4),
        .first_round_o(f4), .last_round_o(l4), .done_valid_o(dv4),
        .done_ready_i(dready), .busy_o(b4)
    );

    logic        u4;
    logic        sr, pe, f, l, dv, bsy;
    logic [31:0] rc;
    assign sr  = u4 ? sr4 : sr1;
    assign pe  = u4 ? pe4 : pe1;
    assign f   = u4 ? f4  : f1;
    assign l   = u4 ? l4  : l1;
    assign dv  = u4 ? dv4 : dv1;
    assign bsy = u4 ? b4  : b1;
    assign rc  = u4 ? rc4 : {24'h0, rc1};

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rcw(input int k0, input int u);
        logic [31:0] r;
        logic [3:0]  k;
        r = '0;
        for (int j = 0; j < u; j++) begin
            k = 4'(k0 + j);
            r[8*j +: 8] = {4'hF - k, k};
        end
        return r;
    endfunction

    task automatic run(input bit four, input bit s, input int st_a,
                       input int st_b, input int hold);
        int u, r, n, c, idx;
        logic [31:0] e;
        u = four ? 4 : 1;
        r = s ? 8 : 12;
        n = r / u;
        c = 0;
        idx = 0;
        u4 = four;
        @(posedge clk); #1;
        sel = s;
        if (four) sv4 = 1'b1; else sv1 = 1'b1;
        @(negedge clk);
        chk("start_ready", 32'(sr), 1);
        chk("idle_busy", 32'(bsy), 0);
        for (int i = 0; i < n; i++) sb.push_back(rcw(12 - r + i * u, u));
        @(posedge clk); #1;
        sv1 = 1'b0;
        sv4 = 1'b0;
        sel = ~s;
        while (sb.size() > 0 && c < 40) begin
            c++;
            stall = (c == st_a) || (c == st_b);
            @(negedge clk);
            chk("run_busy", 32'(bsy), 1);
            chk("run_done", 32'(dv), 0);
            if (stall) begin
                chk("stall_en", 32'(pe), 0);
                chk("stall_rc", rc, 0);
                chk("stall_first", 32'(f), 0);
                chk("stall_last", 32'(l), 0);
            end else begin
                idx++;
                e = sb.pop_front();
                chk("en", 32'(pe), 1);
                chk("rc", rc, e);
                chk("first", 32'(f), 32'(idx == 1));
                chk("last", 32'(l), 32'(idx == n));
            end
            @(posedge clk); #1;
        end
        stall = 1'b0;
        chk("sb_drain_timeout", 32'(sb.size()), 0);
        sb.delete();
        if (four) sv4 = 1'b1; else sv1 = 1'b1;
        stall = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("done_hold", 32'(dv), 1);
            chk("done_en", 32'(pe), 0);
            chk("done_sr", 32'(sr), 0);
            @(posedge clk); #1;
        end
        dready = 1'b1;
        @(negedge clk);
        chk("done_hs", 32'(dv), 1);
        @(posedge clk); #1;
        dready = 1'b0;
        stall = 1'b0;
        sv1 = 1'b0;
        sv4 = 1'b0;
        @(negedge clk);
        chk("post_sr", 32'(sr), 1);
        chk("post_dv", 32'(dv), 0);
        chk("post_busy", 32'(bsy), 0);
    endtask

    initial begin
        rst = 1'b1;
        sv1 = 1'b0;
        sv4 = 1'b0;
        sel = 1'b0;
        stall = 1'b0;
        dready = 1'b0;
        u4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs1", {25'h0, sr1, pe1, f1, l1, dv1, b1, |rc1}, 0);
        chk("rst_outs4", {25'h0, sr4, pe4, f4, l4, dv4, b4, |rc4}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_sr1", 32'(sr1), 1);
        chk("rst_rel_sr4", 32'(sr4), 1);

        run(1'b0, 1'b0, 0, 0, 0);
        run(1'b0, 1'b1, 0, 0, 0);
        run(1'b0, 1'b1, 3, 4, 0);
        run(1'b0, 1'b0, 0, 0, 5);
        run(1'b1, 1'b0, 0, 0, 0);
        run(1'b1, 1'b1, 0, 0, 2);

        u4 = 1'b0;
        @(posedge clk); #1;
        sel = 1'b0;
        sv1 = 1'b1;
        @(posedge clk); #1;
        sv1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_outs", {25'h0, sr1, pe1, f1, l1, dv1, b1, |rc1}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_sr", 32'(sr1), 1);
        chk("midrst_busy", 32'(b1), 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(dv1), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
